ofm_drain: RTL and testbench

//  Drain-side controller for the output-stationary PE array. On a drain request it:
//   - asserts write_out_en for SYSTOLIC_SIZE cycles;
//   - captures one column of row results per cycle into an internal FIFO;
//   - pulses reset_pe to clear the accumulators;
//   - streams the captured columns to the output buffer over a valid/ready interface.

---
 rtl/ofm_drain_if.sv | 39 +++
 rtl/ofm_drain.sv | 185 ++++++++++++++++++
 tb/tb_ofm_drain.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofm_drain_if.sv
`default_nettype none
// ============================================================================
// Interface : ofm_drain_if
// Brief     : Column-stream bus from the OFM drain controller to the OFM
//             buffer writer (valid/ready with column index and last flag).
// Revision  : 1.0 - initial release
// ============================================================================
interface ofm_drain_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int SYSTOLIC_SIZE = 16
);
  localparam int LANE_W = 2 * DATA_WIDTH;
  localparam int COL_W  = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;

  logic                              ofm_valid;
  logic                              ofm_ready;
  logic [SYSTOLIC_SIZE*LANE_W-1:0]   ofm_data;
  logic [COL_W-1:0]                  ofm_col;
  logic                              ofm_last;

  // Drain controller side: produces columns
  modport master (
    output ofm_valid,
    output ofm_data,
    output ofm_col,
    output ofm_last,
    input  ofm_ready
  );

  // Buffer writer side: consumes columns
  modport slave (
    input  ofm_valid,
    input  ofm_data,
    input  ofm_col,
    input  ofm_last,
    output ofm_ready
  );
endinterface
`default_nettype wire

// File: rtl/ofm_drain.sv
`default_nettype none
// ============================================================================
// Module   : ofm_drain
// Brief    : Drain controller for the output-stationary PE array. Shifts one
//            tile out of the array, captures the columns into a tile-deep
//            FIFO, clears the accumulators and streams the columns out.
// Revision : 1.0 - initial release
// ============================================================================
module ofm_drain #(
  parameter int DATA_WIDTH    = 8,
  parameter int SYSTOLIC_SIZE = 16,
  parameter int CAP_LAT       = 1,
  parameter int RELU_EN       = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start_drain,
  input  logic [SYSTOLIC_SIZE*2*DATA_WIDTH-1:0] ofm_in,
  output logic                                 write_out_en,
  output logic                                 reset_pe,
  output logic                                 busy,
  output logic                                 done,
  ofm_drain_if.master                          ofm
);

  localparam int LANE_W = 2 * DATA_WIDTH;
  localparam int WORD_W = SYSTOLIC_SIZE * LANE_W;
  localparam int COL_W  = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
  localparam int CNT_W  = $clog2(SYSTOLIC_SIZE + 1);
  localparam int LAT_W  = (CAP_LAT > 1) ? $clog2(CAP_LAT) : 1;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(SYSTOLIC_SIZE - 1);
  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(CAP_LAT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  logic [1:0]         state_q,     state_d;
  logic [COL_W-1:0]   shift_cnt_q, shift_cnt_d;
  logic [LAT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CAP_LAT-1:0] cap_dly_q,   cap_dly_d;
  logic [COL_W-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [COL_W-1:0]   rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0]   count_q,     count_d;
  logic               done_pend_q, done_pend_d;

  logic [WORD_W-1:0]  mem_q [SYSTOLIC_SIZE];

  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [WORD_W-1:0]  head;
  logic [WORD_W-1:0]  head_act;

  function automatic logic [COL_W-1:0] ptr_inc(input logic [COL_W-1:0] p);
    return (p == LAST_COL) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (count_q == '0);
  assign push       = cap_dly_q[CAP_LAT-1];
  assign pop        = ofm.ofm_valid && ofm.ofm_ready;

  // State, counters, capture delay line and FIFO bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_cnt_q <= '0;
      flush_cnt_q <= '0;
      cap_dly_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      cap_dly_q   <= cap_dly_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      done_pend_q <= done_pend_d;
    end
  end

  // Next-state: a drain only starts from IDLE with an empty FIFO, so a whole
  // tile always fits and the array never needs stalling
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_drain && fifo_empty) begin
          state_d     = S_SHIFT;
          shift_cnt_d = '0;
        end
      end
      S_SHIFT: begin
        if (shift_cnt_q == LAST_COL) begin
          state_d     = S_FLUSH;
          flush_cnt_d = '0;
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == LAST_LAT) begin
          state_d = S_CLEAR;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; done waits for IDLE so a fast downstream cannot see it
  // before the accumulators have been cleared
  always_comb begin
    write_out_en = (state_q == S_SHIFT);
    reset_pe     = (state_q == S_CLEAR);
    busy         = (state_q != S_IDLE) || !fifo_empty;
    done         = done_pend_q && (state_q == S_IDLE);
  end

  // Capture-valid delay line mirrors the array's write_out_en-to-ofm_out latency
  always_comb begin
    cap_dly_d    = '0;
    cap_dly_d[0] = write_out_en;
    for (int i = 1; i < CAP_LAT; i++) begin
      cap_dly_d[i] = cap_dly_q[i-1];
    end
  end

  // FIFO pointers, occupancy and the pending-done flag
  always_comb begin
    wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d     = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    done_pend_d = done_pend_q;
    if (pop && (rd_ptr_q == LAST_COL)) begin
      done_pend_d = 1'b1;
    end else if (done) begin
      done_pend_d = 1'b0;
    end
  end

  // Column storage; contents are only observable while the FIFO is non-empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ofm_in;
    end
  end

  assign head = mem_q[rd_ptr_q];

  // Optional ReLU on each lane at the FIFO output
  for (genvar r = 0; r < SYSTOLIC_SIZE; r++) begin : g_lane
    logic [LANE_W-1:0] lane;
    assign lane = head[r*LANE_W +: LANE_W];
    if (RELU_EN != 0) begin : g_relu
      assign head_act[r*LANE_W +: LANE_W] = lane[LANE_W-1] ? '0 : lane;
    end else begin : g_pass
      assign head_act[r*LANE_W +: LANE_W] = lane;
    end
  end

  // Every drain starts with both pointers equal and pushes exactly one tile,
  // so the read pointer is the column index of the head word
  assign ofm.ofm_valid = !fifo_empty;
  assign ofm.ofm_data  = fifo_empty ? '0 : head_act;
  assign ofm.ofm_col   = fifo_empty ? '0 : rd_ptr_q;
  assign ofm.ofm_last  = !fifo_empty && (rd_ptr_q == LAST_COL);

endmodule
`default_nettype wire

// File: tb/tb_ofm_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofm_drain
// Brief    : Directed self-checking bench for ofm_drain (S=16, CAP_LAT=1),
//            one pass-through instance and one ReLU instance side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofm_drain;

  localparam int S = 16;
  localparam int W = 256;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_drain;
  logic         ready;
  logic [W-1:0] ofm_in;

  logic woe_a, rpe_a, busy_a, done_a;
  logic woe_b, rpe_b, busy_b, done_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int k_in, pat_mode;
  int exp_col_a, exp_col_b;
  int woe_cnt, woe_first, woe_last, rpe_cnt, done_cnt_a, done_cnt_b;
  int start_cyc;

  always #5 clk = ~clk;

  ofm_drain_if #(.DATA_WIDTH(8), .SYSTOLIC_SIZE(S)) bus_a ();
  ofm_drain_if #(.DATA_WIDTH(8), .SYSTOLIC_SIZE(S)) bus_b ();

  assign bus_a.ofm_ready = ready;
  assign bus_b.ofm_ready = ready;

  ofm_drain #(.DATA_WIDTH(8), .SYSTOLIC_SIZE(S), .CAP_LAT(1), .RELU_EN(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_drain(start_drain), .ofm_in(ofm_in),
    .write_out_en(woe_a), .reset_pe(rpe_a), .busy(busy_a), .done(done_a),
    .ofm(bus_a.master)
  );

  ofm_drain #(.DATA_WIDTH(8), .SYSTOLIC_SIZE(S), .CAP_LAT(1), .RELU_EN(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_drain(start_drain), .ofm_in(ofm_in),
    .write_out_en(woe_b), .reset_pe(rpe_b), .busy(busy_b), .done(done_b),
    .ofm(bus_b.master)
  );

  // Column k as the PE array would present it, lane r in bits [r*16 +: 16]
  function automatic logic [W-1:0] make_col(input int k, input int mode);
    logic [W-1:0] c;
    logic [15:0]  v;
    c = '0;
    for (int r = 0; r < S; r++) begin
      case (mode)
        1:       v = (r % 2 == 0) ? 16'h8001 : 16'h7FFF;
        2:       v = 16'(32'h1000 + r * 16 + k);
        default: v = 16'(r * 16 + k);
      endcase
      c[r*16 +: 16] = v;
    end
    return c;
  endfunction

  function automatic logic [W-1:0] relu(input logic [W-1:0] c);
    logic [W-1:0] o;
    o = c;
    for (int r = 0; r < S; r++) begin
      if (c[r*16 + 15]) o[r*16 +: 16] = 16'h0000;
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_counts();
    k_in       = 0;
    exp_col_a  = 0;
    exp_col_b  = 0;
    woe_cnt    = 0;
    woe_first  = -1;
    woe_last   = -1;
    rpe_cnt    = 0;
    done_cnt_a = 0;
    done_cnt_b = 0;
  endtask

  // Observe the current cycle, advance one clock, then model the array:
  // a column appears on ofm_in one cycle after each write_out_en cycle
  task automatic step();
    logic wo;
    if (woe_a) begin
      if (woe_cnt == 0) woe_first = cyc;
      woe_last = cyc;
      woe_cnt++;
    end
    if (rpe_a) rpe_cnt++;
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
    if (bus_a.ofm_valid) begin
      chk("a_data", bus_a.ofm_data, make_col(exp_col_a, pat_mode));
      chk("a_col",  W'(bus_a.ofm_col), W'(exp_col_a));
      chk("a_last", W'(bus_a.ofm_last), W'(exp_col_a == S - 1));
      if (ready) exp_col_a++;
    end else begin
      chk("a_idle_data", bus_a.ofm_data, '0);
    end
    if (bus_b.ofm_valid) begin
      chk("b_data", bus_b.ofm_data, relu(make_col(exp_col_b, pat_mode)));
      chk("b_col",  W'(bus_b.ofm_col), W'(exp_col_b));
      if (ready) exp_col_b++;
    end
    wo = woe_a;
    @(posedge clk);
    #1;
    cyc++;
    if (wo) begin
      ofm_in = make_col(k_in, pat_mode);
      k_in++;
    end
  endtask

  task automatic pulse_start();
    start_drain = 1'b1;
    step();
    start_drain = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_woe"},   W'(woe_a), '0);
    chk({tag, "_rpe"},   W'(rpe_a), '0);
    chk({tag, "_busy"},  W'(busy_a), '0);
    chk({tag, "_done"},  W'(done_a), '0);
    chk({tag, "_valid"}, W'(bus_a.ofm_valid), '0);
    chk({tag, "_data"},  bus_a.ofm_data, '0);
    chk({tag, "_col"},   W'(bus_a.ofm_col), '0);
    chk({tag, "_last"},  W'(bus_a.ofm_last), '0);
    chk({tag, "_b_valid"}, W'(bus_b.ofm_valid), '0);
    chk({tag, "_b_busy"},  W'(busy_b), '0);
  endtask

  task automatic chk_drain(input string tag);
    chk({tag, "_woe_cnt"},   W'(woe_cnt), W'(16));
    chk({tag, "_woe_span"},  W'(woe_last - woe_first), W'(15));
    chk({tag, "_words_a"},   W'(exp_col_a), W'(16));
    chk({tag, "_words_b"},   W'(exp_col_b), W'(16));
    chk({tag, "_rpe_cnt"},   W'(rpe_cnt), W'(1));
    chk({tag, "_done_a"},    W'(done_cnt_a), W'(1));
    chk({tag, "_done_b"},    W'(done_cnt_b), W'(1));
    chk({tag, "_idle"},      W'(busy_a), '0);
  endtask

  initial begin
    rst_n       = 1'b1;
    start_drain = 1'b0;
    ready       = 1'b1;
    ofm_in      = '0;
    pat_mode    = 0;
    reset_counts();

    // Reset state
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_all_zero("rst_hold");
    rst_n = 1'b1;
    step();

    // Test 1/2: basic drain, lane r of column k = r*16+k
    reset_counts();
    pat_mode  = 0;
    start_cyc = cyc;
    pulse_start();
    chk("t1_woe_cycle1", W'(woe_a), W'(1));
    chk("t1_valid_c1",   W'(bus_a.ofm_valid), '0);
    step();
    chk("t1_valid_c2",   W'(bus_a.ofm_valid), '0);
    step();
    chk("t1_valid_c3",   W'(bus_a.ofm_valid), W'(1));
    chk("t1_first_col",  W'(bus_a.ofm_col), '0);
    repeat (37) step();
    chk("t1_woe_first",  W'(woe_first - start_cyc), W'(1));
    chk("t1_woe_last",   W'(woe_last - start_cyc), W'(16));
    chk_drain("t1");

    // Test 3 (+ start with FIFO non-empty): downstream stalled for the drain
    reset_counts();
    pat_mode = 2;
    ready    = 1'b0;
    pulse_start();
    repeat (24) step();
    chk("t3_woe_cnt",  W'(woe_cnt), W'(16));
    chk("t3_count",    W'(u_dut_a.count_q), W'(16));
    chk("t3_no_words", W'(exp_col_a), '0);
    chk("t3_no_done",  W'(done_cnt_a), '0);
    chk("t3_rpe_cnt",  W'(rpe_cnt), W'(1));
    chk("t3_busy",     W'(busy_a), W'(1));
    pulse_start();
    repeat (4) step();
    chk("t4_full_start_ignored", W'(woe_cnt), W'(16));
    ready = 1'b1;
    repeat (25) step();
    chk_drain("t3");

    // Test 4: start_drain while busy shifting
    reset_counts();
    pat_mode = 0;
    pulse_start();
    repeat (4) step();
    pulse_start();
    repeat (35) step();
    chk_drain("t4");

    // Test 5: ReLU lanes (even lanes 8001 -> 0, odd lanes 7FFF pass)
    reset_counts();
    pat_mode = 1;
    pulse_start();
    step();
    step();
    chk("t5_b_lane0", W'(bus_b.ofm_data[15:0]),  W'(16'h0000));
    chk("t5_b_lane1", W'(bus_b.ofm_data[31:16]), W'(16'h7FFF));
    chk("t5_a_lane0", W'(bus_a.ofm_data[15:0]),  W'(16'h8001));
    repeat (37) step();
    chk_drain("t5");

    // Test 6: reset at shift count 7, then a clean drain
    reset_counts();
    pat_mode = 2;
    pulse_start();
    repeat (7) step();
    chk("t6_pre_woe", W'(woe_a), W'(1));
    chk("t6_pre_cnt", W'(u_dut_a.shift_cnt_q), W'(7));
    rst_n = 1'b0;
    #1 chk_all_zero("t6_rst");
    step();
    step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("t6_no_done", W'(done_cnt_a), '0);
    chk_all_zero("t6_after");
    reset_counts();
    pat_mode = 0;
    pulse_start();
    repeat (39) step();
    chk_drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
